data_mem: RTL and testbench
===========================

# data_mem

Single-port data memory slave that services the load/store unit's `data_req`/`data_gnt`/`data_rvalid` bus. It sits directly downstream of the LSU. Each transaction proceeds as follows: it is granted, held for a programmable number of wait states, performed on a byte-enabled synchronous RAM, then answered with exactly one `data_rvalid` pulse carrying read data and an error flag. One transaction is outstanding at a time.

## Interface
Parameters:
- `ADDR_WIDTH`, 10 — word-address bits; memory holds 2^ADDR_WIDTH 32-bit words.
- `WAIT_STATES`, 0 — extra cycles between grant and RAM access; legal range 0..7.

Ports:
- `clk` input 1 — single clock; all logic on rising edge.
- `rst` input 1 — synchronous, active-high reset.
- `data_req` input 1 — LSU request valid.
- `data_we` input 1 — 1 = write, 0 = read.
- `data_be` input 4 — byte enables, bit i ↔ `data_wdata[8i+7:8i]`.
- `data_addr` input 32 — byte address.
- `data_wdata` input 32 — write data.
- `data_gnt` output 1 — request accepted this cycle.
- `data_rvalid` output 1 — response valid, one-cycle pulse.
- `data_rdata` output 32 — read data.
- `data_err` output 1 — response is an error; qualified by `data_rvalid`.

## Operation
- States: IDLE, WAIT, ACCESS, RESP.
- IDLE
  - `data_gnt = data_req` (combinational, only in IDLE).
  - On `data_req` high at the edge: capture `data_we`, `data_be`, `data_addr`, `data_wdata`.
  - Next state is WAIT if `WAIT_STATES > 0`, else ACCESS.
- WAIT
  - 3-bit counter loaded with `WAIT_STATES-1` at grant and decremented each cycle.
  - Moves to ACCESS when the counter is 0.
- ACCESS
  - RAM enabled with word index `addr[ADDR_WIDTH+1:2]`.
  - A write commits the enabled bytes at the edge leaving ACCESS.
  - A read registers the RAM word at that same edge.
  - Next state: RESP.
- RESP
  - `data_rvalid = 1` for exactly one cycle.
  - Next state: IDLE.
- `data_gnt` is 0 in WAIT, ACCESS and RESP. `data_req` asserted in those states is ignored; the LSU must hold it until granted.
- Writes also produce one `data_rvalid` pulse. Their `data_rdata` is the pre-write word at that address (read-before-write).
- `data_be = 4'b0000` on a write: no bytes change; the response is still issued.
- `data_addr[1:0]` must be 00.
- Error conditions: nonzero `data_addr[1:0]`, or nonzero `data_addr[31:ADDR_WIDTH+2]` (see Configuration).
  - On error: no RAM write, `data_rdata = 0`, `data_err = 1` in RESP.
- `data_rdata` holds the last response value between responses. `data_err` is 0 outside RESP.

## Timing
- Reset values: `data_gnt` 0 (state IDLE), `data_rvalid` 0, `data_rdata` 0, `data_err` 0, wait counter 0. RAM contents are not reset.
- Latency: grant accepted at edge t, then ACCESS at cycle t+1+W, then `data_rvalid` high in cycle t+2+W.
- Earliest next grant is cycle t+3+W. Throughput is one access per 3+W cycles.
- Reset in WAIT or ACCESS aborts the transaction: no RAM write, no `data_rvalid`. Reset asserted in the ACCESS cycle suppresses the write.
- Reset in RESP forces `data_rvalid` low from the next cycle.
- `data_req` and `rst` high in the same cycle: reset wins; no capture occurs and `data_gnt` is still driven by the IDLE state.

## Configuration
- `DATA_MEM_ERR_EN` defined:
  - Out-of-range addresses (nonzero `addr[31:ADDR_WIDTH+2]`) and misaligned addresses raise `data_err` as described above.
- `DATA_MEM_ERR_EN` undefined:
  - No checks. Address wraps modulo 2^ADDR_WIDTH words and `addr[1:0]` is ignored.
  - `data_err` is tied to 0.
  - Every access performs its RAM operation.

## Structure
- Package `data_mem_pkg`:
  - state enum (IDLE, WAIT, ACCESS, RESP)
  - `WORD_BYTES = 4`
  - `MAX_WAIT_STATES = 7`
- Sub-module `data_mem_sram`: single-port synchronous RAM, parameters `ADDR_WIDTH`, ports `clk`, `en`, `we`, `be[3:0]`, `addr`, `wdata`, `rdata`. It has registered read with read-before-write and contains no reset logic.
- Top level holds the FSM, wait counter, request capture registers, error decode and response registers.

## Test plan
- Read after write, W=0: write 0xDEADBEEF with be=1111 to 0x10, then read 0x10.
  - Each `data_rvalid` arrives 2 cycles after its grant.
  - The read returns 0xDEADBEEF with `data_err` = 0.
- Partial write: word 0x20 holds 0x11223344; write 0xAABBCCDD with be=0101.
  - A read of 0x20 returns 0x11BB33DD.
  - The write's own response returns 0x11223344.
- Wait states, W=3: a read is granted at t.
  - `data_rvalid` is high only in cycle t+5.
  - `data_gnt` stays 0 through t+5 while `data_req` is held high, then is 1 at t+6.
- Out-of-range read of 0x0000_1000 (ADDR_WIDTH=10):
  - With `DATA_MEM_ERR_EN`: `data_err` = 1 and `data_rdata` = 0.
  - Without it: returns word 0 contents with `data_err` = 0.
- Error write with `DATA_MEM_ERR_EN`: misaligned write to 0x12.
  - `data_err` = 1.
  - A read of 0x10 is unchanged.
- Reset mid-write, W=2: assert `rst` one cycle after granting a write of 0xCAFEF00D to 0x40.
  - No `data_rvalid` appears.
  - A later read of 0x40 returns its old value.
  - All outputs are at reset values the cycle after `rst`.

Source files
------------

// File: rtl/data_mem_pkg.sv
// Shared types and constants for the data_mem LSU slave.
package data_mem_pkg;

  // Transaction phases of the slave FSM.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam int WORD_BYTES      = 4;
  localparam int MAX_WAIT_STATES = 7;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  // True when a byte address is not word aligned or lies above the
  // implemented word range of a memory with addr_width word-address bits.
  function automatic logic addr_fault(input logic [31:0] addr,
                                      input int unsigned addr_width);
    logic [31:0] upper;
    upper = addr >> (addr_width + 32'd2);
    return (addr[1:0] != 2'b00) || (upper != 32'h0000_0000);
  endfunction

endpackage

// File: rtl/data_mem_sram.sv
// Single-port synchronous RAM with byte enables. The read port is
// registered and returns the word as it was before a same-cycle write.
// Contents are intentionally not reset.
module data_mem_sram
  import data_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [3:0]            be,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [31:0] mem_r [DEPTH];

  // Capture the old word and overwrite only the enabled byte lanes.
  always_ff @(posedge clk) begin
    if (en) begin
      rdata <= mem_r[addr];
      for (int i = 0; i < WORD_BYTES; i++) begin
        if (we && be[i]) begin
          mem_r[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/data_mem.sv
// data_mem: single-outstanding data memory slave for the LSU
// data_req/data_gnt/data_rvalid bus. Each request is granted in IDLE,
// optionally held for WAIT_STATES cycles, performed on the byte-enabled
// RAM in ACCESS and answered with one data_rvalid pulse in RESP.
// Optional feature macro: DATA_MEM_ERR_EN enables misaligned and
// out-of-range address errors; without it addresses wrap and data_err is 0.
module data_mem
  import data_mem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_req,
  input  logic        data_we,
  input  logic [3:0]  data_be,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_gnt,
  output logic        data_rvalid,
  output logic [31:0] data_rdata,
  output logic        data_err
);

  // Wait states are clamped to what the 3-bit counter can express.
  localparam int WAIT_EFF = (WAIT_STATES > MAX_WAIT_STATES) ? MAX_WAIT_STATES :
                            (WAIT_STATES < 0) ? 0 : WAIT_STATES;
  localparam bit HAS_WAIT = (WAIT_EFF > 0);
  localparam logic [2:0] WAIT_LOAD = HAS_WAIT ? 3'(WAIT_EFF - 1) : 3'd0;

  state_t                  state_r;
  state_t                  state_next_s;
  logic [2:0]              wait_cnt_r;
  logic                    accept_s;
  logic                    req_fault_s;

  logic                    cap_we_r;
  logic [3:0]              cap_be_r;
  logic [ADDR_WIDTH-1:0]   cap_idx_r;
  logic [31:0]             cap_wdata_r;
  logic                    cap_err_r;

  logic                    ram_en_s;
  logic                    ram_we_s;
  logic [31:0]             ram_rdata_s;

  logic                    rvalid_r;
  logic                    err_r;
  logic                    zero_r;

  // A request is accepted whenever the slave sits in IDLE; reset does not
  // mask the grant itself, it only blocks the capture.
  assign accept_s = (state_r == IDLE) && data_req;

`ifdef DATA_MEM_ERR_EN
  assign req_fault_s = addr_fault(data_addr, ADDR_WIDTH);
`else
  // Alignment and upper address bits are deliberately ignored: addresses wrap.
  logic unused_addr_s;
  assign unused_addr_s = ^{data_addr[31:ADDR_WIDTH+2], data_addr[1:0]};
  assign req_fault_s   = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state decode.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (data_req) begin
          state_next_s = HAS_WAIT ? WAIT : ACCESS;
        end else begin
          state_next_s = IDLE;
        end
      end
      WAIT: begin
        if (wait_cnt_r == 3'd0) begin
          state_next_s = ACCESS;
        end else begin
          state_next_s = WAIT;
        end
      end
      ACCESS:  state_next_s = RESP;
      RESP:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Wait-state down-counter: loaded at grant, counts down while waiting.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_r <= 3'd0;
    end else if (accept_s) begin
      wait_cnt_r <= WAIT_LOAD;
    end else if ((state_r == WAIT) && (wait_cnt_r != 3'd0)) begin
      wait_cnt_r <= wait_cnt_r - 3'd1;
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end

  // Latch the request fields and its error verdict at the grant edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_we_r    <= 1'b0;
      cap_be_r    <= 4'b0000;
      cap_idx_r   <= '0;
      cap_wdata_r <= 32'h0000_0000;
      cap_err_r   <= 1'b0;
    end else if (accept_s) begin
      cap_we_r    <= data_we;
      cap_be_r    <= data_be;
      cap_idx_r   <= data_addr[ADDR_WIDTH+1:2];
      cap_wdata_r <= data_wdata;
      cap_err_r   <= req_fault_s;
    end else begin
      cap_we_r    <= cap_we_r;
      cap_be_r    <= cap_be_r;
      cap_idx_r   <= cap_idx_r;
      cap_wdata_r <= cap_wdata_r;
      cap_err_r   <= cap_err_r;
    end
  end

  // RAM strobes: only in ACCESS, never for a faulting request, and killed by
  // a reset in that same cycle so an aborted write cannot land.
  always_comb begin
    ram_en_s = 1'b0;
    ram_we_s = 1'b0;
    if ((state_r == ACCESS) && !rst && !cap_err_r) begin
      ram_en_s = 1'b1;
      ram_we_s = cap_we_r;
    end else begin
      ram_en_s = 1'b0;
      ram_we_s = 1'b0;
    end
  end

  data_mem_sram #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_sram (
    .clk   (clk),
    .en    (ram_en_s),
    .we    (ram_we_s),
    .be    (cap_be_r),
    .addr  (cap_idx_r),
    .wdata (cap_wdata_r),
    .rdata (ram_rdata_s)
  );

  // Response flags: one-cycle rvalid/err pulse leaving ACCESS; zero_r forces
  // the read data to zero after reset and for faulting responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_r <= 1'b0;
      err_r    <= 1'b0;
      zero_r   <= 1'b1;
    end else if (state_r == ACCESS) begin
      rvalid_r <= 1'b1;
      err_r    <= cap_err_r;
      zero_r   <= cap_err_r;
    end else begin
      rvalid_r <= 1'b0;
      err_r    <= 1'b0;
      zero_r   <= zero_r;
    end
  end

  // The RAM read register only updates in ACCESS, so it holds the last
  // response word until the next one.
  assign data_gnt    = accept_s;
  assign data_rvalid = rvalid_r;
  assign data_err    = err_r;
  assign data_rdata  = zero_r ? ZERO_WORD : ram_rdata_s;

endmodule

// File: tb/tb_data_mem.sv
// Directed self-checking bench for data_mem. Three instances cover
// WAIT_STATES = 0, 3 and 2; expectations depend on DATA_MEM_ERR_EN.
`timescale 1ns/1ps
module tb_data_mem;

  logic        clk = 1'b0;
  logic        rst    [3];
  logic        req    [3];
  logic        we     [3];
  logic [3:0]  be     [3];
  logic [31:0] addr   [3];
  logic [31:0] wdata  [3];
  logic        gnt    [3];
  logic        rvalid [3];
  logic [31:0] rdata  [3];
  logic        err    [3];

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  data_mem #(.ADDR_WIDTH(10), .WAIT_STATES(0)) u_dm0 (
    .clk(clk), .rst(rst[0]), .data_req(req[0]), .data_we(we[0]), .data_be(be[0]),
    .data_addr(addr[0]), .data_wdata(wdata[0]), .data_gnt(gnt[0]),
    .data_rvalid(rvalid[0]), .data_rdata(rdata[0]), .data_err(err[0]));

  data_mem #(.ADDR_WIDTH(10), .WAIT_STATES(3)) u_dm3 (
    .clk(clk), .rst(rst[1]), .data_req(req[1]), .data_we(we[1]), .data_be(be[1]),
    .data_addr(addr[1]), .data_wdata(wdata[1]), .data_gnt(gnt[1]),
    .data_rvalid(rvalid[1]), .data_rdata(rdata[1]), .data_err(err[1]));

  data_mem #(.ADDR_WIDTH(10), .WAIT_STATES(2)) u_dm2 (
    .clk(clk), .rst(rst[2]), .data_req(req[2]), .data_we(we[2]), .data_be(be[2]),
    .data_addr(addr[2]), .data_wdata(wdata[2]), .data_gnt(gnt[2]),
    .data_rvalid(rvalid[2]), .data_rdata(rdata[2]), .data_err(err[2]));

  // Issue one transaction on instance k; lat counts cycles from grant cycle
  // to the rvalid cycle. ok is 0 if grant or response never came.
  task automatic txn(input int k, input logic w, input logic [3:0] b,
                     input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic er,
                     output int lat, output bit ok);
    bit granted;
    granted = 1'b0;
    ok  = 1'b0;
    rd  = 32'h0;
    er  = 1'b0;
    lat = 0;
    @(negedge clk);
    req[k] = 1'b1; we[k] = w; be[k] = b; addr[k] = a; wdata[k] = d;
    for (int i = 0; i < 40 && !granted; i++) begin
      #1;
      if (gnt[k] === 1'b1) granted = 1'b1;
      else @(negedge clk);
    end
    if (granted) begin
      @(posedge clk);
      #1;
      req[k] = 1'b0;
      for (int c = 1; c <= 40; c++) begin
        @(negedge clk);
        if (rvalid[k] === 1'b1) begin
          rd = rdata[k]; er = err[k]; lat = c; ok = 1'b1;
          break;
        end
      end
    end else begin
      req[k] = 1'b0;
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1; req[k] = 1'b0; we[k] = 1'b0; be[k] = 4'h0;
      addr[k] = 32'h0; wdata[k] = 32'h0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) rst[k] = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      vectors++; if (gnt[k] !== 1'b0) begin miscompares++; $display("FAIL reset_gnt[%0d]: got %b want 0", k, gnt[k]); end
      vectors++; if (rvalid[k] !== 1'b0) begin miscompares++; $display("FAIL reset_rvalid[%0d]: got %b want 0", k, rvalid[k]); end
      vectors++; if (rdata[k] !== 32'h0) begin miscompares++; $display("FAIL reset_rdata[%0d]: got %h want 0", k, rdata[k]); end
      vectors++; if (err[k] !== 1'b0) begin miscompares++; $display("FAIL reset_err[%0d]: got %b want 0", k, err[k]); end
    end
  endtask

  task automatic test_raw();
    logic [31:0] rd; logic er; int lat; bit ok;
    txn(0, 1'b1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF, rd, er, lat, ok);
    vectors++; if (!ok || lat != 2) begin miscompares++; $display("FAIL raw_wr_latency: got %0d want 2 (ok=%0d)", lat, ok); end
    vectors++; if (er !== 1'b0) begin miscompares++; $display("FAIL raw_wr_err: got %b want 0", er); end
    txn(0, 1'b0, 4'hF, 32'h0000_0010, 32'h0, rd, er, lat, ok);
    vectors++; if (!ok || lat != 2) begin miscompares++; $display("FAIL raw_rd_latency: got %0d want 2 (ok=%0d)", lat, ok); end
    vectors++; if (rd !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL raw_rd_data: got %h want deadbeef", rd); end
    vectors++; if (er !== 1'b0) begin miscompares++; $display("FAIL raw_rd_err: got %b want 0", er); end
    @(negedge clk);
    vectors++; if (rvalid[0] !== 1'b0) begin miscompares++; $display("FAIL raw_pulse: got %b want 0", rvalid[0]); end
    vectors++; if (rdata[0] !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL raw_hold: got %h want deadbeef", rdata[0]); end
  endtask

  task automatic test_partial();
    logic [31:0] rd; logic er; int lat; bit ok;
    txn(0, 1'b1, 4'hF, 32'h0000_0020, 32'h1122_3344, rd, er, lat, ok);
    txn(0, 1'b1, 4'b0101, 32'h0000_0020, 32'hAABB_CCDD, rd, er, lat, ok);
    vectors++; if (!ok || rd !== 32'h1122_3344) begin miscompares++; $display("FAIL partial_wr_resp: got %h want 11223344", rd); end
    txn(0, 1'b0, 4'hF, 32'h0000_0020, 32'h0, rd, er, lat, ok);
    vectors++; if (!ok || rd !== 32'h11BB_33DD) begin miscompares++; $display("FAIL partial_rd: got %h want 11bb33dd", rd); end
  endtask

  task automatic test_be_zero();
    logic [31:0] rd; logic er; int lat; bit ok;
    txn(0, 1'b1, 4'b0000, 32'h0000_0020, 32'hFFFF_FFFF, rd, er, lat, ok);
    vectors++; if (!ok || rd !== 32'h11BB_33DD) begin miscompares++; $display("FAIL be0_resp: got %h want 11bb33dd", rd); end
    txn(0, 1'b0, 4'hF, 32'h0000_0020, 32'h0, rd, er, lat, ok);
    vectors++; if (!ok || rd !== 32'h11BB_33DD) begin miscompares++; $display("FAIL be0_rd: got %h want 11bb33dd", rd); end
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd; logic er; int lat; bit ok;
    txn(0, 1'b1, 4'hF, 32'h0000_0000, 32'h55AA_55AA, rd, er, lat, ok);
    txn(0, 1'b0, 4'hF, 32'h0000_1000, 32'h0, rd, er, lat, ok);
`ifdef DATA_MEM_ERR_EN
    vectors++; if (!ok || er !== 1'b1) begin miscompares++; $display("FAIL oor_err: got %b want 1", er); end
    vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL oor_rdata: got %h want 0", rd); end
`else
    vectors++; if (!ok || er !== 1'b0) begin miscompares++; $display("FAIL oor_err: got %b want 0", er); end
    vectors++; if (rd !== 32'h55AA_55AA) begin miscompares++; $display("FAIL oor_rdata: got %h want 55aa55aa", rd); end
`endif
    @(negedge clk);
    vectors++; if (err[0] !== 1'b0) begin miscompares++; $display("FAIL oor_err_after: got %b want 0", err[0]); end
  endtask

  task automatic test_err_write();
    logic [31:0] rd; logic er; int lat; bit ok;
    txn(0, 1'b1, 4'hF, 32'h0000_0012, 32'h1234_5678, rd, er, lat, ok);
`ifdef DATA_MEM_ERR_EN
    vectors++; if (!ok || er !== 1'b1) begin miscompares++; $display("FAIL errwr_err: got %b want 1", er); end
    vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL errwr_rdata: got %h want 0", rd); end
    txn(0, 1'b0, 4'hF, 32'h0000_0010, 32'h0, rd, er, lat, ok);
    vectors++; if (!ok || rd !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL errwr_mem: got %h want deadbeef", rd); end
`else
    vectors++; if (!ok || er !== 1'b0) begin miscompares++; $display("FAIL errwr_err: got %b want 0", er); end
    vectors++; if (rd !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL errwr_rdata: got %h want deadbeef", rd); end
    txn(0, 1'b0, 4'hF, 32'h0000_0010, 32'h0, rd, er, lat, ok);
    vectors++; if (!ok || rd !== 32'h1234_5678) begin miscompares++; $display("FAIL errwr_mem: got %h want 12345678", rd); end
`endif
  endtask

  task automatic test_wait_states();
    bit granted;
    granted = 1'b0;
    @(negedge clk);
    req[1] = 1'b1; we[1] = 1'b0; be[1] = 4'hF; addr[1] = 32'h0000_0010; wdata[1] = 32'h0;
    for (int i = 0; i < 20 && !granted; i++) begin
      #1;
      if (gnt[1] === 1'b1) granted = 1'b1;
      else @(negedge clk);
    end
    vectors++; if (!granted) begin miscompares++; $display("FAIL ws_grant: got no grant want grant"); end
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      vectors++; if (gnt[1] !== (c == 6)) begin miscompares++; $display("FAIL ws_gnt t+%0d: got %b want %b", c, gnt[1], (c == 6)); end
      vectors++; if (rvalid[1] !== (c == 5)) begin miscompares++; $display("FAIL ws_rvalid t+%0d: got %b want %b", c, rvalid[1], (c == 5)); end
    end
    req[1] = 1'b0;
  endtask

  task automatic test_back_to_back();
    int c1, c2;
    logic [31:0] rd;
    c1 = -1; c2 = -1; rd = 32'h0;
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b0; be[0] = 4'hF; addr[0] = 32'h0000_0020; wdata[0] = 32'h0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (gnt[0] === 1'b1) begin c1 = cyc; break; end
      @(negedge clk);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (rvalid[0] === 1'b1) rd = rdata[0];
      if (gnt[0] === 1'b1) begin c2 = cyc; break; end
    end
    req[0] = 1'b0;
    vectors++; if (c1 < 0 || c2 < 0 || (c2 - c1) != 3) begin miscompares++; $display("FAIL b2b_spacing: got %0d want 3", c2 - c1); end
    vectors++; if (rd !== 32'h11BB_33DD) begin miscompares++; $display("FAIL b2b_rdata: got %h want 11bb33dd", rd); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er; int lat; bit ok; bit seen; bit granted;
    txn(2, 1'b1, 4'hF, 32'h0000_0040, 32'h0BAD_C0DE, rd, er, lat, ok);
    vectors++; if (!ok || lat != 4) begin miscompares++; $display("FAIL rm_pre_latency: got %0d want 4", lat); end
    for (int j = 0; j < 2; j++) begin
      int d;
      d = (j == 0) ? 1 : 3;
      granted = 1'b0;
      @(negedge clk);
      req[2] = 1'b1; we[2] = 1'b1; be[2] = 4'hF; addr[2] = 32'h0000_0040; wdata[2] = 32'hCAFE_F00D;
      for (int i = 0; i < 20 && !granted; i++) begin
        #1;
        if (gnt[2] === 1'b1) granted = 1'b1;
        else @(negedge clk);
      end
      @(posedge clk);
      #1;
      req[2] = 1'b0;
      repeat (d - 1) begin @(posedge clk); #1; end
      rst[2] = 1'b1;
      @(posedge clk);
      #1;
      rst[2] = 1'b0;
      @(negedge clk);
      vectors++; if (gnt[2] !== 1'b0 || rvalid[2] !== 1'b0 || rdata[2] !== 32'h0 || err[2] !== 1'b0) begin
        miscompares++; $display("FAIL rm_outputs d=%0d: got gnt=%b rv=%b rd=%h err=%b want 0/0/0/0", d, gnt[2], rvalid[2], rdata[2], err[2]);
      end
      seen = 1'b0;
      repeat (6) begin @(negedge clk); if (rvalid[2] === 1'b1) seen = 1'b1; end
      vectors++; if (seen) begin miscompares++; $display("FAIL rm_no_rvalid d=%0d: got rvalid want none", d); end
      txn(2, 1'b0, 4'hF, 32'h0000_0040, 32'h0, rd, er, lat, ok);
      vectors++; if (!ok || rd !== 32'h0BAD_C0DE) begin miscompares++; $display("FAIL rm_mem d=%0d: got %h want 0badc0de", d, rd); end
    end
    // Request and reset together: grant is visible but nothing is captured.
    @(negedge clk);
    rst[2] = 1'b1; req[2] = 1'b1; we[2] = 1'b0; addr[2] = 32'h0000_0040;
    #1;
    vectors++; if (gnt[2] !== 1'b1) begin miscompares++; $display("FAIL rm_gnt_in_rst: got %b want 1", gnt[2]); end
    @(posedge clk);
    #1;
    rst[2] = 1'b0; req[2] = 1'b0;
    seen = 1'b0;
    repeat (6) begin @(negedge clk); if (rvalid[2] === 1'b1) seen = 1'b1; end
    vectors++; if (seen) begin miscompares++; $display("FAIL rm_req_rst: got rvalid want none"); end
  endtask

  initial begin
    test_reset();
    test_raw();
    test_partial();
    test_be_zero();
    test_out_of_range();
    test_err_write();
    test_wait_states();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
